// File: rtl/pipe_pkg.sv
// Shared constants for the 5-stage core pipeline registers.
// RV_NOP is the bubble value for the IF/ID instruction field.
package pipe_pkg;

  localparam int XLEN    = 32;
  localparam int STATS_W = 16;

  // Canonical RISC-V NOP: addi x0, x0, 0
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Per-stage payload widths (PC + instruction, operands, results, writeback).
  localparam int IFID_W  = 2 * XLEN;
  localparam int IDEX_W  = 4 * XLEN + 32;
  localparam int EXMEM_W = 3 * XLEN + 10;
  localparam int MEMWB_W = 2 * XLEN + 7;

  // Number of held entries given the two valid flags.
  function automatic logic [1:0] occ_count(input logic a, input logic b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream valid/ready/data,
// downstream valid/ready/data and the occupancy status.
// PIPE_STAGE_STATS_EN adds the bubble/stall counter outputs.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [15:0]      bubble_cnt;
  logic [15:0]      stall_cnt;
`endif

  // Environment side: drives the upstream word and the downstream ready.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
`ifdef PIPE_STAGE_STATS_EN
    , input bubble_cnt, stall_cnt
`endif
  );

  // Stage side: the pipeline register itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
`ifdef PIPE_STAGE_STATS_EN
    , output bubble_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/pipe_stage_stats.sv
// Saturating bubble / stall counters for a pipeline stage register.
// Cleared only by CLR_N; the flush edge itself is not counted.
module pipe_stage_stats
  import pipe_pkg::*;
(
  input  logic               CLK,
  input  logic               CLR_N,
  input  logic               FLUSH,
  input  logic               out_valid,
  input  logic               out_ready,
  output logic [STATS_W-1:0] bubble_cnt,
  output logic [STATS_W-1:0] stall_cnt
);

  logic [STATS_W-1:0] bubble_cnt_reg;
  logic [STATS_W-1:0] stall_cnt_reg;

  // Count empty-output and blocked-output cycles, holding at all-ones.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      bubble_cnt_reg <= '0;
      stall_cnt_reg  <= '0;
    end else if (!FLUSH) begin
      if (!out_valid && (bubble_cnt_reg != '1))
        bubble_cnt_reg <= bubble_cnt_reg + STATS_W'(1);
      if (out_valid && !out_ready && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + STATS_W'(1);
    end
  end

  assign bubble_cnt = bubble_cnt_reg;
  assign stall_cnt  = stall_cnt_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake and a 2-entry
// skid buffer (main + skid), so in_ready depends only on local state.
// FLUSH squashes both entries. Optional macro: PIPE_STAGE_STATS_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = XLEN,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                  CLK,
  input  logic                  CLR_N,
  input  logic                  FLUSH,
  pipe_stage_reg_if.slave       bus
);

  logic [WIDTH-1:0] main_data_reg;
  logic             main_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             skid_valid_reg;

  logic acc;
  logic pop;

  // in_ready comes straight from the skid flag: no combinational path
  // from out_ready back to the upstream stage.
  assign acc = bus.in_valid & ~skid_valid_reg;
  assign pop = main_valid_reg & bus.out_ready;

  // Main/skid update; data registers only load on real transfer events.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= RESET_VAL;
      skid_data_reg  <= RESET_VAL;
    end else if (FLUSH) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_data_reg  <= RESET_VAL;
      skid_data_reg  <= RESET_VAL;
    end else if (!main_valid_reg || pop) begin
      if (skid_valid_reg) begin
        main_data_reg  <= skid_data_reg;
        main_valid_reg <= 1'b1;
        if (acc) begin
          skid_data_reg <= bus.in_data;
        end else begin
          skid_valid_reg <= 1'b0;
        end
      end else if (acc) begin
        main_data_reg  <= bus.in_data;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (acc) begin
      skid_data_reg  <= bus.in_data;
      skid_valid_reg <= 1'b1;
    end
  end

  assign bus.in_ready  = ~skid_valid_reg;
  assign bus.out_valid = main_valid_reg;
  assign bus.out_data  = main_data_reg;
  assign bus.occupancy = occ_count(main_valid_reg, skid_valid_reg);

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats u_stats (
    .CLK        (CLK),
    .CLR_N      (CLR_N),
    .FLUSH      (FLUSH),
    .out_valid  (main_valid_reg),
    .out_ready  (bus.out_ready),
    .bubble_cnt (bus.bubble_cnt),
    .stall_cnt  (bus.stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, backpressure, flush,
// sustained pop-and-refill, NOP reset value, and (with PIPE_STAGE_STATS_EN)
// the saturating statistics counters.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic CLK;
  logic CLR_N;
  logic FLUSH;
  int   vectors;
  int   errors;

  pipe_stage_reg_if #(.WIDTH(32)) bus0 ();
  pipe_stage_reg_if #(.WIDTH(32)) bus1 ();

  // Second instance uses RV_NOP as its reset value and mirrors the stimulus.
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.out_ready = bus0.out_ready;

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut0 (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .FLUSH (FLUSH),
    .bus   (bus0.slave)
  );

  pipe_stage_reg #(.WIDTH(32), .RESET_VAL(RV_NOP)) dut1 (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .FLUSH (FLUSH),
    .bus   (bus1.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 32'h01;
    tick();
    bus0.in_data = 32'h02;
    tick();
    bus0.in_valid = 1'b0;
    vectors++;
    if (bus0.occupancy !== 2'd2) begin
      errors++; $display("FAIL pre_reset_occ got=%0d exp=2", bus0.occupancy);
    end
    #2 CLR_N = 1'b0;
    #1;
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_out_valid got=%b exp=0", bus0.out_valid);
    end
    vectors++;
    if (bus0.in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready got=%b exp=1", bus0.in_ready);
    end
    vectors++;
    if (bus0.occupancy !== 2'd0) begin
      errors++; $display("FAIL rst_occ got=%0d exp=0", bus0.occupancy);
    end
    vectors++;
    if (bus0.out_data !== 32'h0) begin
      errors++; $display("FAIL rst_out_data got=%h exp=00000000", bus0.out_data);
    end
    vectors++;
    if (bus1.out_data !== 32'h00000013) begin
      errors++; $display("FAIL rst_nop_data got=%h exp=00000013", bus1.out_data);
    end
    $display("reset asserted mid-stream: occ=%0d out_valid=%b", bus0.occupancy, bus0.out_valid);
    @(negedge CLK);
    CLR_N = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus0.in_valid = 1'b1;
      bus0.in_data  = words[i];
      tick();
      vectors++;
      if (bus0.out_valid !== 1'b1 || bus0.out_data !== words[i]) begin
        errors++;
        $display("FAIL stream_word%0d got=%b/%h exp=1/%h", i, bus0.out_valid, bus0.out_data, words[i]);
      end
      $display("stream push %h -> out %h", words[i], bus0.out_data);
    end
    bus0.in_valid = 1'b0;
    tick();
    vectors++;
    if (bus0.out_valid !== 1'b0 || bus0.occupancy !== 2'd0) begin
      errors++; $display("FAIL stream_drain got=%b/%0d exp=0/0", bus0.out_valid, bus0.occupancy);
    end
  endtask

  task automatic test_backpressure();
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 32'hA1;
    tick();
    bus0.in_data = 32'hA2;
    vectors++;
    if (bus0.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_ready_a2 got=%b exp=1", bus0.in_ready);
    end
    tick();
    bus0.in_data = 32'hA3;
    vectors++;
    if (bus0.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_a3 got=%b exp=0", bus0.in_ready);
    end
    tick();
    vectors++;
    if (bus0.occupancy !== 2'd2 || bus0.out_data !== 32'hA1) begin
      errors++; $display("FAIL bp_hold got=%0d/%h exp=2/000000a1", bus0.occupancy, bus0.out_data);
    end
    $display("backpressure: occ=%0d in_ready=%b head=%h", bus0.occupancy, bus0.in_ready, bus0.out_data);
    bus0.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus0.out_data !== 32'hA2 || bus0.occupancy !== 2'd1 || bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_pop1 got=%h/%0d/%b exp=000000a2/1/1", bus0.out_data, bus0.occupancy, bus0.in_ready);
    end
    tick();
    vectors++;
    if (bus0.out_data !== 32'hA3 || bus0.occupancy !== 2'd1) begin
      errors++; $display("FAIL bp_pop2 got=%h/%0d exp=000000a3/1", bus0.out_data, bus0.occupancy);
    end
    bus0.in_valid = 1'b0;
    tick();
    vectors++;
    if (bus0.occupancy !== 2'd0) begin
      errors++; $display("FAIL bp_drain got=%0d exp=0", bus0.occupancy);
    end
  endtask

  task automatic test_flush();
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 32'hB1;
    tick();
    bus0.in_data = 32'hB2;
    tick();
    vectors++;
    if (bus0.occupancy !== 2'd2) begin
      errors++; $display("FAIL flush_pre_occ got=%0d exp=2", bus0.occupancy);
    end
    FLUSH          = 1'b1;
    bus0.in_data   = 32'hFF;
    bus0.out_ready = 1'b1;
    tick();
    FLUSH         = 1'b0;
    bus0.in_valid = 1'b0;
    vectors++;
    if (bus0.out_valid !== 1'b0 || bus0.occupancy !== 2'd0 || bus0.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_state got=%b/%0d/%b exp=0/0/1", bus0.out_valid, bus0.occupancy, bus0.in_ready);
    end
    vectors++;
    if (bus0.out_data !== 32'h0) begin
      errors++; $display("FAIL flush_data got=%h exp=00000000", bus0.out_data);
    end
    vectors++;
    if (bus1.out_data !== 32'h00000013) begin
      errors++; $display("FAIL flush_nop_data got=%h exp=00000013", bus1.out_data);
    end
    tick();
    vectors++;
    if (bus0.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_emit got=%b exp=0", bus0.out_valid);
    end
    $display("flush: occ=%0d out_data=%h nop_data=%h", bus0.occupancy, bus0.out_data, bus1.out_data);
  endtask

  task automatic test_back_to_back();
    bus0.out_ready = 1'b0;
    bus0.in_valid  = 1'b1;
    bus0.in_data   = 32'hC0;
    tick();
    bus0.out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      bus0.in_data = 32'hD000 + k;
      tick();
      vectors++;
      if (bus0.occupancy !== 2'd1 || bus0.in_ready !== 1'b1 || bus0.out_data !== (32'hD000 + k)) begin
        errors++;
        $display("FAIL b2b_cycle%0d got=%0d/%b/%h exp=1/1/%h", k, bus0.occupancy, bus0.in_ready,
                 bus0.out_data, 32'hD000 + k);
      end
    end
    $display("back-to-back: 100 words, last out=%h", bus0.out_data);
    bus0.in_valid = 1'b0;
    tick();
    vectors++;
    if (bus0.occupancy !== 2'd0) begin
      errors++; $display("FAIL b2b_drain got=%0d exp=0", bus0.occupancy);
    end
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b0;
    @(negedge CLK);
    CLR_N = 1'b0;
    #1;
    vectors++;
    if (bus0.bubble_cnt !== 16'd0 || bus0.stall_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_rst got=%0d/%0d exp=0/0", bus0.bubble_cnt, bus0.stall_cnt);
    end
    @(negedge CLK);
    CLR_N = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus0.in_valid = 1'b1;
    bus0.in_data  = 32'hE1;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (bus0.bubble_cnt !== 16'd5 || bus0.stall_cnt !== 16'd3) begin
      errors++; $display("FAIL stats_counts got=%0d/%0d exp=5/3", bus0.bubble_cnt, bus0.stall_cnt);
    end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    vectors++;
    if (bus0.bubble_cnt !== 16'd5 || bus0.stall_cnt !== 16'd3) begin
      errors++; $display("FAIL stats_flush_edge got=%0d/%0d exp=5/3", bus0.bubble_cnt, bus0.stall_cnt);
    end
    bus0.in_valid = 1'b1;
    bus0.in_data  = 32'hE2;
    tick();
    bus0.in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) tick();
    vectors++;
    if (bus0.stall_cnt !== 16'hFFFF || bus0.bubble_cnt !== 16'd6) begin
      errors++; $display("FAIL stats_saturate got=%h/%0d exp=ffff/6", bus0.stall_cnt, bus0.bubble_cnt);
    end
    $display("stats: bubble=%0d stall=%h", bus0.bubble_cnt, bus0.stall_cnt);
    bus0.out_ready = 1'b1;
    tick();
  endtask
`endif

  initial begin
    vectors        = 0;
    errors         = 0;
    CLR_N          = 1'b0;
    FLUSH          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_data   = 32'h0;
    bus0.out_ready = 1'b0;
    #23;
    CLR_N = 1'b1;
    @(negedge CLK);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_back_to_back();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake and a 2-entry skid buffer, so a stage can stall without a combinational ready path across stages.
- Synchronous FLUSH inserts a bubble on branch mispredict or hazard squash.
- Latency 1 cycle; full throughput (1 word/cycle) when the downstream stage is ready.

Parameters:
- WIDTH, 32, payload width in bits; must be at least 1.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into both data registers on reset and on flush.

Ports:
- CLK  input  1  clock, rising edge.
- CLR_N  input  1  asynchronous active-low reset.
- FLUSH  input  1  synchronous squash of all held entries; highest priority.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  out_data holds a valid entry (main_valid).
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  main register contents.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- State:
  - main register (main_data, main_valid).
  - skid register (skid_data, skid_valid).
  - Invariant: skid_valid implies main_valid.
- Fire signals: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Async reset (CLR_N=0):
  - main_valid=0, skid_valid=0; both data registers = RESET_VAL.
  - Outputs: out_valid=0, in_ready=1, occupancy=0, out_data=RESET_VAL.
- Reset release is synchronised externally; the block needs no first-cycle special case.
- FLUSH=1 at a rising edge:
  - Both valids cleared; both data registers = RESET_VAL.
  - acc and pop on that cycle are ignored: input is discarded, and downstream must treat the flushed word as not transferred.
  - Next cycle: out_valid=0, in_ready=1.
- Normal update, no flush, evaluated per edge:
  - Main empty, or pop: main loads skid if skid_valid, else in_data if acc, else main_valid goes 0. In the skid case, skid also loads in_data if acc, else skid_valid goes 0.
  - Main full, no pop, and acc: skid loads in_data, skid_valid=1. in_ready drops next cycle.
  - Main full, no pop, no acc: hold.
- Ordering is strictly FIFO; no entry is ever dropped or duplicated outside a flush.
- Stall boundary: out_ready low with a continuous input stream gives exactly one extra accept (into skid), then in_ready=0.
- Full state (occupancy=2): simultaneous pop and acc is impossible because in_ready=0.
- Latency:
  - Word accepted into an empty stage appears on out_data the next cycle.
  - A word in skid appears 1 cycle after the pop that frees main.
- Data registers update only on load events, never on idle cycles, to limit toggle power.
- occupancy = main_valid + skid_valid.

Optional Feature:
- Macro: PIPE_STAGE_STATS_EN.
- Defined:
  - Adds outputs bubble_cnt[15:0] and stall_cnt[15:0].
  - bubble_cnt increments each cycle with out_valid=0.
  - stall_cnt increments each cycle with out_valid=1 and out_ready=0.
  - Both counters saturate at 16'hFFFF, are cleared only by CLR_N (not by FLUSH), and do not count during the flush edge itself.
- Undefined: the ports and logic are absent; the functional behaviour above is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - RV_NOP = 32'h00000013, the RESET_VAL for the IF/ID instruction field.
  - XLEN = 32.
  - STATS_W = 16.
  - The per-stage payload width constants IFID_W, IDEX_W, EXMEM_W, MEMWB_W.
- One natural sub-module: pipe_stage_stats (the two saturating counters), instantiated only under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset then stream: assert CLR_N=0 mid-stream while holding 2 entries -> out_valid=0, in_ready=1, occupancy=0, out_data=0 immediately. Release, push 0x11,0x22,0x33 with out_ready=1 -> outputs 0x11,0x22,0x33 on consecutive cycles, 1-cycle latency.
- Backpressure: out_ready=0, push 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted, in_ready=0 on the third attempt, occupancy=2. Raise out_ready -> 0xA1,0xA2,0xA3 delivered in order, none lost.
- Flush with full skid: occupancy=2, FLUSH=1 with in_valid=1 on data 0xFF -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL, 0xFF never emitted.
- Pop-and-refill: occupancy=1, out_ready=1, in_valid=1 each cycle for 100 cycles -> occupancy stays 1, in_ready stays 1, throughput 1 word/cycle.
- RESET_VAL=RV_NOP, WIDTH=32 -> after reset and after flush, out_data=32'h00000013.
- With PIPE_STAGE_STATS_EN: 5 idle cycles then 3 stalled cycles -> bubble_cnt=5, stall_cnt=3. Force 70000 stall cycles -> stall_cnt=16'hFFFF (saturates).
